// File: rtl/trace_pkg.sv
// trace_pkg
// Shared types for the retired-instruction trace unit.
//   trace_state_t : capture/readout FSM encoding (visible on the state port)
//   trace_entry_t : one captured retire record at the default core width
//   XLEN_DEF      : default width of pc, instruction and write-back data
package trace_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_POST  = 2'd2,
    ST_DONE  = 2'd3
  } trace_state_t;

  typedef struct packed {
    logic [XLEN_DEF-1:0] pc;
    logic [XLEN_DEF-1:0] inst;
    logic [XLEN_DEF-1:0] wdata;
  } trace_entry_t;

endpackage

// File: rtl/trace_ram.sv
// trace_ram
// Circular-buffer storage: DEPTH words of WIDTH bits, one synchronous write
// port and one asynchronous (show-ahead) read port. Contents are not reset.
//   clock  : write clock
//   we     : write enable
//   waddr  : write address
//   wdata  : write data
//   raddr  : read address
//   rdata  : read data, combinational from raddr
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 96,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/trace_capture.sv
// trace_capture
// Retired-instruction trace unit. Records committed instructions into a
// circular buffer once armed, fires on any enabled PC comparator, keeps
// post_count further entries, then requests a core halt and drains the
// stored window oldest-first over a valid/ready port.
//   clock, nreset          : clock, asynchronous active-low reset
//   retire_*               : retire tap from the core (valid, pc, inst, wdata)
//   arm                    : pulse; clear the buffer and start capture
//   trig_en, trig_pc       : per-comparator enable and word-aligned address
//   post_count             : entries kept after the trigger entry
//   state, trig_id, wrapped: capture status
//   halt_req               : core stall request, high while in DONE
//   rd_*                   : show-ahead readout port
module trace_capture
  import trace_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int XLEN  = 32,
  parameter int NTRIG = 2,
  parameter int CW    = $clog2(DEPTH) + 1,
  parameter int TW    = (NTRIG > 1) ? $clog2(NTRIG) : 1
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic                  retire_valid,
  input  logic [XLEN-1:0]       retire_pc,
  input  logic [XLEN-1:0]       retire_inst,
  input  logic [XLEN-1:0]       retire_wdata,
  input  logic                  arm,
  input  logic [NTRIG-1:0]      trig_en,
  input  logic [NTRIG*XLEN-1:0] trig_pc,
  input  logic [CW-1:0]         post_count,
  output logic [1:0]            state,
  output logic [TW-1:0]         trig_id,
  output logic                  wrapped,
  output logic                  halt_req,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [XLEN-1:0]       rd_pc,
  output logic [XLEN-1:0]       rd_inst,
  output logic [XLEN-1:0]       rd_wdata,
  output logic                  rd_last
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  trace_state_t  state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] remaining_q, remaining_d;
  logic          wrapped_q, wrapped_d;
  logic [TW-1:0] trig_id_q, trig_id_d;

  logic            wr_en;
  logic            trig_hit;
  logic [TW-1:0]   trig_sel;
  logic            enter_done;
  logic            rd_pop;
  logic [3*XLEN-1:0] ram_rdata;

  // Comparators: address bits [1:0] are dropped by shifting the XOR, so the
  // match is on the word address only. Scanning downward lets the lowest
  // matching index win.
  always_comb begin
    trig_hit = 1'b0;
    trig_sel = '0;
    for (int i = NTRIG - 1; i >= 0; i--) begin
      if (trig_en[i] &&
          (((trig_pc[i*XLEN +: XLEN] ^ retire_pc) >> 2) == '0)) begin
        trig_hit = 1'b1;
        trig_sel = TW'(i);
      end
    end
  end

  assign rd_valid = (state_q == ST_DONE) && (count_q != '0);
  assign rd_pop   = rd_valid && rd_ready;

  // Next-state logic. arm overrides everything, including a same-cycle
  // retire. In DONE, count_q doubles as the number of entries left to read.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    count_d     = count_q;
    remaining_d = remaining_q;
    wrapped_d   = wrapped_q;
    trig_id_d   = trig_id_q;
    wr_en       = 1'b0;
    enter_done  = 1'b0;

    if (arm) begin
      state_d     = ST_ARMED;
      wptr_d      = '0;
      rptr_d      = '0;
      count_d     = '0;
      remaining_d = '0;
      wrapped_d   = 1'b0;
      trig_id_d   = '0;
    end else begin
      case (state_q)
        ST_ARMED, ST_POST: begin
          if (retire_valid) begin
            wr_en  = 1'b1;
            wptr_d = wptr_q + AW'(1);
            if (count_q == FULL) begin
              wrapped_d = 1'b1;
            end else begin
              count_d = count_q + CW'(1);
            end
            if (state_q == ST_ARMED) begin
              if (trig_hit) begin
                trig_id_d = trig_sel;
                if (post_count == '0) begin
                  enter_done = 1'b1;
                end else begin
                  state_d     = ST_POST;
                  remaining_d = post_count;
                end
              end
            end else begin
              remaining_d = remaining_q - CW'(1);
              if (remaining_q == CW'(1)) begin
                enter_done = 1'b1;
              end
            end
            // Oldest entry sits count entries behind the write pointer; when
            // full the low bits of count are zero and rptr equals wptr.
            if (enter_done) begin
              state_d = ST_DONE;
              rptr_d  = wptr_d - count_d[AW-1:0];
            end
          end
        end
        ST_DONE: begin
          if (rd_pop) begin
            rptr_d  = rptr_q + AW'(1);
            count_d = count_q - CW'(1);
            if (count_q == CW'(1)) begin
              state_d = ST_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      rptr_q      <= '0;
      count_q     <= '0;
      remaining_q <= '0;
      wrapped_q   <= 1'b0;
      trig_id_q   <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      count_q     <= count_d;
      remaining_q <= remaining_d;
      wrapped_q   <= wrapped_d;
      trig_id_q   <= trig_id_d;
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .WIDTH (3 * XLEN),
    .AW    (AW)
  ) u_ram (
    .clock (clock),
    .we    (wr_en),
    .waddr (wptr_q),
    .wdata ({retire_pc, retire_inst, retire_wdata}),
    .raddr (rptr_q),
    .rdata (ram_rdata)
  );

  assign state    = state_q;
  assign trig_id  = trig_id_q;
  assign wrapped  = wrapped_q;
  assign halt_req = (state_q == ST_DONE);
  assign rd_last  = rd_valid && (count_q == CW'(1));
  assign rd_pc    = rd_valid ? ram_rdata[3*XLEN-1:2*XLEN] : '0;
  assign rd_inst  = rd_valid ? ram_rdata[2*XLEN-1:XLEN]   : '0;
  assign rd_wdata = rd_valid ? ram_rdata[XLEN-1:0]        : '0;

endmodule
